// File: rtl/ebus_arbiter_pkg.sv
// Shared constants for the external-bus arbiter: data width, FSM state
// encodings and default burst/turnaround limits.
package ebus_arbiter_pkg;

  localparam int EBUS_DATA_SIZE        = 8;
  localparam int EBUS_MAX_BURST_DEF    = 16;
  localparam int EBUS_TURN_CYCLES_DEF  = 1;

  typedef enum logic [1:0] {
    EBUS_ARB_IDLE = 2'd0,
    EBUS_ARB_OWN  = 2'd1,
    EBUS_ARB_TURN = 2'd2
  } ebus_arb_state_e;

endpackage

// File: rtl/ebus_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping, as a one-hot select plus its index.
module ebus_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDXW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    ptr,
  output logic [NUM_REQ-1:0] sel,
  output logic [IDXW-1:0]    idx
);

  int j;

  // Scan from the farthest offset down so the nearest hit to ptr wins last.
  always_comb begin
    sel = '0;
    idx = '0;
    j   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (req[j]) begin
        sel    = '0;
        sel[j] = 1'b1;
        idx    = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/ebus_arbiter.sv
// Round-robin owner of the external-bus driver stage: bounded bursts,
// registered data/enable, and a forced enable-low turnaround between owners.
module ebus_arbiter
  import ebus_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int MAX_BURST   = EBUS_MAX_BURST_DEF,
  parameter int TURN_CYCLES = EBUS_TURN_CYCLES_DEF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ-1:0]                req_done,
  input  logic [NUM_REQ*EBUS_DATA_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]                gnt,
  output logic [EBUS_DATA_SIZE-1:0]         ebus_data_out,
  output logic                              ebus_enable,
  output logic                              ebus_busy
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam int CW   = $clog2(MAX_BURST + 1);
  localparam int TW   = 3;

  ebus_arb_state_e             state, state_n;
  logic [IDXW-1:0]             owner, owner_n;
  logic [IDXW-1:0]             ptr, ptr_n;
  logic [CW-1:0]               count, count_n;
  logic [TW-1:0]               turn_cnt, turn_n;
  logic [NUM_REQ-1:0]          gnt_n;
  logic [EBUS_DATA_SIZE-1:0]   data_n;
  logic                        en_n;

  logic [NUM_REQ-1:0]          pick_sel;
  logic [IDXW-1:0]             pick_idx;
  logic                        own_req, own_done;

  ebus_rr_pick #(.NUM_REQ(NUM_REQ), .IDXW(IDXW)) u_pick (
    .req (req),
    .ptr (ptr),
    .sel (pick_sel),
    .idx (pick_idx)
  );

  assign own_req   = req[owner];
  assign own_done  = req_done[owner];
  assign ebus_busy = (state != EBUS_ARB_IDLE);

  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n   = ptr;
    count_n = count;
    turn_n  = turn_cnt;
    gnt_n   = gnt;
    data_n  = ebus_data_out;
    en_n    = 1'b0;
    case (state)
      EBUS_ARB_IDLE: begin
        if (|req) begin
          state_n = EBUS_ARB_OWN;
          gnt_n   = pick_sel;
          owner_n = pick_idx;
          count_n = '0;
          ptr_n   = (pick_idx == IDXW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
        end
      end
      EBUS_ARB_OWN: begin
        if (own_req) begin
          data_n  = req_data[owner*EBUS_DATA_SIZE +: EBUS_DATA_SIZE];
          en_n    = 1'b1;
          count_n = count + 1'b1;
        end
        // The limit word is still accepted; release happens on the same edge.
        if (!own_req || own_done || count == CW'(MAX_BURST - 1)) begin
          state_n = EBUS_ARB_TURN;
          gnt_n   = '0;
          turn_n  = TW'(TURN_CYCLES);
        end
      end
      EBUS_ARB_TURN: begin
        if (turn_cnt == '0) state_n = EBUS_ARB_IDLE;
        else                turn_n  = turn_cnt - 1'b1;
      end
      default: begin
        state_n = EBUS_ARB_IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= EBUS_ARB_IDLE;
      owner         <= '0;
      ptr           <= '0;
      count         <= '0;
      turn_cnt      <= '0;
      gnt           <= '0;
      ebus_data_out <= '0;
      ebus_enable   <= 1'b0;
    end else begin
      state         <= state_n;
      owner         <= owner_n;
      ptr           <= ptr_n;
      count         <= count_n;
      turn_cnt      <= turn_n;
      gnt           <= gnt_n;
      ebus_data_out <= data_n;
      ebus_enable   <= en_n;
    end
  end

endmodule

// File: tb/tb_ebus_arbiter.sv
// Bench for ebus_arbiter: vector table, directed corner sequences and a
// randomized run against a burst/gap-counting reference model.
module tb_ebus_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;
  localparam int TC = 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req, req_done, gnt;
  logic [N*W-1:0]   req_data;
  logic [W-1:0]     ebus_data_out;
  logic             ebus_enable, ebus_busy;

  always #5 clk = ~clk;

  ebus_arbiter #(.NUM_REQ(N), .MAX_BURST(MB), .TURN_CYCLES(TC)) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_done      (req_done),
    .req_data      (req_data),
    .gnt           (gnt),
    .ebus_data_out (ebus_data_out),
    .ebus_enable   (ebus_enable),
    .ebus_busy     (ebus_busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; req_done = '0; req_data = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Reference model: owner index (-1 = none), words in the current burst,
  // cycles still to wait before arbitration may run again.
  int         m_own, m_words, m_gap, m_next;
  logic       m_en;
  logic [7:0] m_data;

  task automatic model_reset();
    m_own = -1; m_words = 0; m_gap = 0; m_next = 0; m_en = 1'b0; m_data = '0;
  endtask

  task automatic model_step();
    bit found;
    if (m_own >= 0) begin
      if (req[m_own]) begin
        m_en   = 1'b1;
        m_data = req_data[m_own*W +: W];
        m_words++;
      end else begin
        m_en = 1'b0;
      end
      if (!req[m_own] || req_done[m_own] || m_words == MB) begin
        m_own = -1;
        m_gap = TC + 1;
      end
    end else begin
      m_en = 1'b0;
      if (m_gap > 0) m_gap--;
      else if (req != 0) begin
        found = 0;
        for (int k = 0; k < N; k++)
          if (!found && req[(m_next + k) % N]) begin
            found = 1;
            m_own = (m_next + k) % N;
          end
        m_words = 0;
        m_next  = (m_own + 1) % N;
      end
    end
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] rq, dn;
    logic [7:0] d0;
    logic [3:0] eg;
    logic       ee;
    logic [7:0] ed;
    logic       eb;
  } vec_t;

  vec_t tbl[9];

  int         order[$];
  int         at[$];
  logic [7:0] words[$];

  initial begin
    int last_en, min_gap, k, o;
    logic g;

    reset = 1'b1; req = '0; req_done = '0; req_data = '0;
    @(negedge clk);

    // Reset hold, release with all requesting, then a 3-word burst on req0.
    tbl[0] = '{1'b1, 4'hF, 4'h0, 8'h00, 4'h0, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{1'b1, 4'hF, 4'h0, 8'h00, 4'h0, 1'b0, 8'h00, 1'b0};
    tbl[2] = '{1'b0, 4'hF, 4'h0, 8'hA1, 4'h1, 1'b0, 8'h00, 1'b1};
    tbl[3] = '{1'b0, 4'h1, 4'hE, 8'hA1, 4'h1, 1'b1, 8'hA1, 1'b1};
    tbl[4] = '{1'b0, 4'h1, 4'h0, 8'hA2, 4'h1, 1'b1, 8'hA2, 1'b1};
    tbl[5] = '{1'b0, 4'h1, 4'h1, 8'hA3, 4'h0, 1'b1, 8'hA3, 1'b1};
    tbl[6] = '{1'b0, 4'h0, 4'h0, 8'h00, 4'h0, 1'b0, 8'hA3, 1'b1};
    tbl[7] = '{1'b0, 4'h0, 4'h0, 8'h00, 4'h0, 1'b0, 8'hA3, 1'b0};
    tbl[8] = '{1'b0, 4'h0, 4'h0, 8'h00, 4'h0, 1'b0, 8'hA3, 1'b0};
    for (int i = 0; i < 9; i++) begin
      reset = tbl[i].rst; req = tbl[i].rq; req_done = tbl[i].dn;
      req_data = {8'hEE, 8'hDD, 8'hCC, tbl[i].d0};
      cyc();
      chk($sformatf("vec%0d_gnt", i),  gnt,           tbl[i].eg);
      chk($sformatf("vec%0d_en", i),   ebus_enable,   tbl[i].ee);
      chk($sformatf("vec%0d_data", i), ebus_data_out, tbl[i].ed);
      chk($sformatf("vec%0d_busy", i), ebus_busy,     tbl[i].eb);
    end

    // Round robin with single-word bursts.
    do_reset();
    req = 4'hF; req_done = 4'hF; req_data = 32'h44332211;
    last_en = -100; min_gap = 1000;
    for (int c = 0; c < 40; c++) begin
      cyc();
      chk("rr_onehot", $onehot0(gnt), 1);
      if (gnt != 0)
        for (int b = 0; b < N; b++) if (gnt[b]) order.push_back(b);
      if (ebus_enable) begin
        if (last_en >= 0 && c - last_en - 1 < min_gap) min_gap = c - last_en - 1;
        last_en = c;
      end
    end
    for (int i = 0; i < 5; i++) chk($sformatf("rr_order%0d", i), order[i], i % N);
    chk("rr_min_gap", min_gap, TC + 2);

    // Burst limit: req2 streams 8 words with no done.
    do_reset();
    req = 4'b0100; k = 0;
    for (int c = 0; c < 40; c++) begin
      req_data = '0;
      req_data[2*W +: W] = 8'(8'h10 + k);
      g = gnt[2];
      cyc();
      if (g) k++;
      if (ebus_enable) begin words.push_back(ebus_data_out); at.push_back(c); end
      if (k >= 8) req = '0;
    end
    chk("burst_nwords", words.size(), 8);
    for (int i = 0; i < 8 && i < words.size(); i++) begin
      chk($sformatf("burst_word%0d", i), words[i], 8'h10 + i);
      if (i > 0) chk($sformatf("burst_spacing%0d", i), at[i] - at[i-1], (i == 4) ? TC + 3 : 1);
    end

    // Abandon: owner 0 drops req after two words; requester 1 is next.
    do_reset();
    req = 4'b0011; req_data = 32'h0;
    cyc();                          chk("ab_gnt0", gnt, 4'b0001);
    req_data[7:0] = 8'h50; cyc();   chk("ab_w0", {ebus_enable, ebus_data_out}, {1'b1, 8'h50});
    req_data[7:0] = 8'h51; cyc();   chk("ab_w1", {ebus_enable, ebus_data_out}, {1'b1, 8'h51});
    req = 4'b0010; cyc();
    chk("ab_drop", {gnt, ebus_enable, ebus_busy}, {4'b0000, 1'b0, 1'b1});
    cyc();                          chk("ab_turn", {gnt, ebus_busy}, {4'b0000, 1'b1});
    cyc();                          chk("ab_idle", {gnt, ebus_busy}, {4'b0000, 1'b0});
    cyc();                          chk("ab_gnt1", gnt, 4'b0010);

    // Async reset mid-burst, then arbitration restarts at requester 0.
    do_reset();
    req = 4'b0001; req_data = 32'h77;
    cyc(); cyc();
    chk("ar_pre_en", ebus_enable, 1'b1);
    #2 reset = 1'b1;
    #1 chk("ar_async", {gnt, ebus_enable, ebus_busy}, 6'b0);
    @(negedge clk);
    reset = 1'b0; req = 4'hF;
    cyc();
    chk("ar_restart_gnt", gnt, 4'b0001);

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1; #2; reset = 1'b0;
        model_reset();
      end
      req ^= 4'($urandom) & 4'($urandom);
      for (int b = 0; b < N; b++) req_done[b] = ($urandom_range(0, 2) == 0);
      req_data = $urandom;
      cyc();
      model_step();
      o = m_own;
      chk("rnd_gnt",  gnt,           (o >= 0) ? (32'd1 << o) : 32'd0);
      chk("rnd_en",   ebus_enable,   m_en);
      chk("rnd_data", ebus_data_out, m_data);
      chk("rnd_busy", ebus_busy,     (o >= 0 || m_gap > 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
